if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  asynchronous reset, active-high.
REQ-004 Port: stall  in  1  decode cannot accept the presented instruction this cycle.
REQ-005 Port: redirect  in  1  one-cycle pulse; a branch or jump is resolved, so refetch from redirect_pc.
REQ-006 Port: redirect_pc  in  32  target PC, sampled when redirect=1.
REQ-007 Port: inst_req  out  1  instruction-SRAM request.
REQ-008 Port: inst_addr  out  32  request address (the fetch PC).
REQ-009 Port: inst_addr_ok  in  1  request accepted this cycle.
REQ-010 Port: inst_data_ok  in  1  read data valid this cycle.
REQ-011 Port: inst_rdata  in  32  read data.
REQ-012 Port: if_valid  out  1  the if_pc, if_inst, op and funct outputs hold a live instruction.
REQ-013 Port: if_pc  out  32  PC of the presented instruction.
REQ-014 Port: if_inst  out  32  presented instruction.
REQ-015 Port: op  out  6  if_inst[31:26], combinational slice for maindec.
REQ-016 Port: funct  out  6  if_inst[5:0], combinational slice for maindec.
REQ-017 Port: if_adel  out  1  the presented entry is a misaligned-fetch exception.
REQ-018 Parameter: RESET_PC  default 32'hBFC00000  PC loaded on reset.

Function
REQ-019 The FSM SHALL have states REQ (drive inst_req), WAIT (one request outstanding) and ERR (misaligned PC; no requests issued).
REQ-020 At most one request SHALL be outstanding; inst_addr SHALL equal fetch_pc and SHALL stay stable while inst_req=1.
REQ-021 In REQ, inst_req SHALL be 1 unless the skid entry is occupied.
REQ-022 REQ SHALL move to WAIT on inst_req and inst_addr_ok both high.
REQ-023 In WAIT, an inst_data_ok with cancel=0 SHALL deliver {fetch_pc, inst_rdata}, set fetch_pc to fetch_pc+4 (mod 2^32, with 32'hFFFFFFFC wrapping to 0), and return to REQ.
REQ-024 A delivered entry SHALL be written to the output register if that register is empty or is being consumed (if_valid=1 and stall=0); otherwise it SHALL be written to the single skid entry.
REQ-025 When the output register is consumed and the skid entry is occupied, the skid entry SHALL move to the output register in the same cycle.
REQ-026 Latency SHALL be: data_ok at cycle N gives if_valid=1 at cycle N+1. From reset release with zero-wait memory, inst_req=1 in the first cycle.
REQ-027 While if_valid=1 and stall=1, if_pc, if_inst and if_adel SHALL hold unchanged.
REQ-028 On redirect=1, the next cycle SHALL have if_valid=0, the skid entry empty and fetch_pc=redirect_pc.
REQ-029 If a request is outstanding (WAIT, or REQ with addr_ok in the redirect cycle), the block SHALL set cancel, discard that request's data_ok, then clear cancel and go to REQ.
REQ-030 Redirect SHALL take priority over stall and over a same-cycle data_ok; the data delivered in that cycle SHALL be dropped.
REQ-031 If fetch_pc[1:0]!=0 in REQ with no outstanding request, the block SHALL issue no request and SHALL present if_valid=1, if_inst=0, if_adel=1, if_pc=fetch_pc, then enter ERR.
REQ-032 ERR SHALL be left only by redirect.
REQ-033 Output-queue ordering SHALL be strict program order.

Reset
REQ-034 While rst=1, asynchronously: fetch_pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_inst=0, if_adel=0, skid empty, cancel=0, inst_req=0.
REQ-035 After rst deasserts, operation SHALL begin on the next clk edge.
REQ-036 An outstanding request at reset SHALL be treated as cancelled; its late data_ok SHALL be ignored.

Verification
REQ-037 Zero-wait memory (addr_ok=data_ok=1, data=0x1000+addr[7:0]), stall=0 -> if_pc sequence BFC00000, BFC00004, BFC00008; op and funct match rdata slices.
REQ-038 stall=1 for 3 cycles while if_valid=1 -> outputs frozen, skid fills, inst_req=0; on release two in-order instructions appear back-to-back, nothing lost or duplicated.
REQ-039 Redirect to 0x80000100 while in WAIT, data_ok 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears; next presented if_pc=0x80000100.
REQ-040 redirect, stall and data_ok all in the same cycle -> next cycle if_valid=0, fetch_pc=redirect_pc.
REQ-041 Redirect to 0x80000102 -> if_valid=1, if_adel=1, if_inst=0, if_pc=0x80000102, no inst_req until the next redirect.
REQ-042 rst asserted mid-WAIT, then a late data_ok -> outputs at reset values; first request addr=BFC00000.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues one instruction-SRAM request at a time (req/addr_ok handshake
// followed by data_ok), delivers fetched instructions in program order
// through an output register backed by a single skid entry, honours
// decode back-pressure (stall), and flushes on redirect. A misaligned
// fetch PC produces a single address-error entry, after which the stage
// idles until the next redirect.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   stall              decode cannot accept the presented instruction
//   redirect           one-cycle pulse: refetch from redirect_pc
//   redirect_pc[31:0]  new fetch PC, sampled when redirect=1
//   inst_req           SRAM request
//   inst_addr[31:0]    SRAM request address (fetch PC)
//   inst_addr_ok       SRAM accepted the request this cycle
//   inst_data_ok       SRAM read data valid this cycle
//   inst_rdata[31:0]   SRAM read data
//   if_valid           if_pc/if_inst/op/funct/if_adel hold a live entry
//   if_pc[31:0]        PC of the presented entry
//   if_inst[31:0]      presented instruction
//   op[5:0]            if_inst[31:26]
//   funct[5:0]         if_inst[5:0]
//   if_adel            presented entry is a misaligned-fetch exception
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        if_adel
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic        cancel, cancel_d;
  logic [31:0] fetch_pc;

  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        skid_adel;

  // Entry produced this cycle (fetched instruction or address error).
  logic        deliver;
  logic [31:0] ent_pc;
  logic [31:0] ent_inst;
  logic        ent_adel;
  logic        consume;

  assign inst_addr = fetch_pc;
  assign op        = if_inst[31:26];
  assign funct     = if_inst[5:0];
  assign consume   = if_valid & ~stall;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    cancel_d = cancel;
    inst_req = 1'b0;
    deliver  = 1'b0;
    ent_pc   = fetch_pc;
    ent_inst = inst_rdata;
    ent_adel = 1'b0;

    unique case (state)
      S_REQ: begin
        // A full skid entry means there is nowhere to put another result.
        if (!skid_valid) begin
          if (fetch_pc[1:0] != 2'b00) begin
            deliver  = 1'b1;
            ent_inst = 32'h0;
            ent_adel = 1'b1;
            state_d  = S_ERR;
          end else begin
            inst_req = 1'b1;
            if (inst_addr_ok) state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (cancel) cancel_d = 1'b0;
          else        deliver  = 1'b1;
        end
      end
      S_ERR: ;
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything. A request still in flight after this
    // cycle must have its data_ok swallowed, which is what cancel tracks.
    if (redirect) begin
      deliver = 1'b0;
      if ((state == S_WAIT && !inst_data_ok) ||
          (state == S_REQ && inst_req && inst_addr_ok)) begin
        state_d  = S_WAIT;
        cancel_d = 1'b1;
      end else begin
        state_d  = S_REQ;
        cancel_d = 1'b0;
      end
    end

    // The state register sits at its reset value while rst is held, so
    // the request has to be masked explicitly.
    if (rst) inst_req = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      cancel   <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      state  <= state_d;
      cancel <= cancel_d;
      if (redirect)                 fetch_pc <= redirect_pc;
      else if (deliver && !ent_adel) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_inst    <= 32'h0;
      if_adel    <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_inst  <= 32'h0;
      skid_adel  <= 1'b0;
    end else if (redirect) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      // Older skid entry goes first to keep program order.
      if_pc   <= skid_pc;
      if_inst <= skid_inst;
      if_adel <= skid_adel;
      if (deliver) begin
        skid_pc   <= ent_pc;
        skid_inst <= ent_inst;
        skid_adel <= ent_adel;
      end else begin
        skid_valid <= 1'b0;
      end
    end else if (consume || !if_valid) begin
      if (deliver) begin
        if_valid <= 1'b1;
        if_pc    <= ent_pc;
        if_inst  <= ent_inst;
        if_adel  <= ent_adel;
      end else begin
        if_valid <= 1'b0;
      end
    end else if (deliver) begin
      // Output register is held by stall: park the new entry.
      skid_valid <= 1'b1;
      skid_pc    <= ent_pc;
      skid_inst  <= ent_inst;
      skid_adel  <= ent_adel;
    end
  end

endmodule
